// File: rtl/packet_source_arbiter_pkg.sv
// Shared definitions for the packet source arbiter.
//   - arb_state_e : arbiter FSM states
//   - *_DEF       : default parameter values of the top module
//   - SRC_W/CNT_W : grant-id and word-counter widths for the default build
//   - clog2_min1  : $clog2 that never yields a zero-width vector
package packet_source_arbiter_pkg;

   localparam int N_SRC_DEF     = 4;
   localparam int DATA_BITS_DEF = 4;
   localparam int MAX_WORDS_DEF = 16;
   localparam int CNT_BITS_DEF  = 16;

   localparam int SRC_W = $clog2(N_SRC_DEF);
   localparam int CNT_W = $clog2(MAX_WORDS_DEF);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_e;

   function automatic int clog2_min1(input int value);
      return (value <= 1) ? 1 : $clog2(value);
   endfunction

endpackage

// File: rtl/packet_source_arbiter_rr_select.sv
// Round-robin selector (purely combinational).
//   req_i      : request vector, one bit per requester
//   last_id_i  : id of the most recently granted requester
//   next_id_o  : first requester with req set, scanning last_id_i+1 upward
//                with wrap; the last granted requester is scanned last
//   any_o      : at least one request is set (next_id_o is valid)
module rr_select #(
   parameter int N = 4,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req_i,
   input  logic [W-1:0] last_id_i,
   output logic [W-1:0] next_id_o,
   output logic         any_o
);

   always_comb begin
      int idx;
      idx       = 0;
      next_id_o = last_id_i;
      any_o     = 1'b0;
      for (int k = 1; k <= N; k++) begin
         idx = (int'(last_id_i) + k) % N;
         if (!any_o && req_i[idx]) begin
            any_o     = 1'b1;
            next_id_o = W'(idx);
         end
      end
   end

endmodule

// File: rtl/packet_source_arbiter.sv
// Packet-atomic round-robin arbiter feeding one packet_framer input port
// from N_SRC source FIFOs. One source is granted per packet; its words are
// passed straight through until its end-of-packet word, then the grant
// rotates. Packets reaching MAX_WORDS words are force-terminated.
// Ports:
//   clk, reset_n         : clock, synchronous active-low reset
//   src_nempty/src_pop   : per-source word-available / pop strobe
//   src_data/src_end     : per-source head word and its end-of-packet flag
//   fr_full/fr_shift     : framer in_full / in_shift
//   fr_data/fr_end       : framer in_data / in_end
//   grant_id             : currently (or last) granted source
//   busy                 : packet transfer in progress
//   trunc_pulse          : 1-cycle strobe after a forced packet end
//   pkt_count            : delivered packet counter (wraps)
module packet_source_arbiter
   import packet_source_arbiter_pkg::*;
#(
   parameter int N_SRC     = N_SRC_DEF,
   parameter int DATA_BITS = DATA_BITS_DEF,
   parameter int MAX_WORDS = MAX_WORDS_DEF,
   parameter int CNT_BITS  = CNT_BITS_DEF
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [N_SRC-1:0]           src_nempty,
   output logic [N_SRC-1:0]           src_pop,
   input  logic [N_SRC*DATA_BITS-1:0] src_data,
   input  logic [N_SRC-1:0]           src_end,
   input  logic                       fr_full,
   output logic                       fr_shift,
   output logic [DATA_BITS-1:0]       fr_data,
   output logic                       fr_end,
   output logic [$clog2(N_SRC)-1:0]   grant_id,
   output logic                       busy,
   output logic                       trunc_pulse,
   output logic [CNT_BITS-1:0]        pkt_count
);

   localparam int GRANT_W = $clog2(N_SRC);
   localparam int WC_W    = clog2_min1(MAX_WORDS);

   arb_state_e          state_q, state_d;
   logic [GRANT_W-1:0]  grant_q, grant_d;
   logic [WC_W-1:0]     word_cnt_q, word_cnt_d;
   logic [CNT_BITS-1:0] pkt_cnt_q, pkt_cnt_d;
   logic                trunc_q, trunc_d;

   logic [GRANT_W-1:0]  rr_next;
   logic                rr_any;

   logic                 sel_nempty;
   logic                 sel_end;
   logic [DATA_BITS-1:0] sel_data;
   logic                 force_end;
   logic                 pop;
   logic                 close;

   rr_select #(
      .N (N_SRC),
      .W (GRANT_W)
   ) u_rr_select (
      .req_i     (src_nempty),
      .last_id_i (grant_q),
      .next_id_o (rr_next),
      .any_o     (rr_any)
   );

   assign sel_nempty = src_nempty[grant_q];
   assign sel_end    = src_end[grant_q];
   assign sel_data   = src_data[grant_q*DATA_BITS +: DATA_BITS];

   // Last word slot available to this packet: close it regardless of src_end.
   assign force_end = (word_cnt_q == WC_W'(MAX_WORDS - 1));

   // reset_n gates the pop so nothing leaves a source while reset is held,
   // even before the state register has been cleared.
   assign pop   = reset_n && (state_q == BUSY) && sel_nempty && !fr_full;
   assign close = pop && (sel_end || force_end);

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      word_cnt_d = word_cnt_q;
      pkt_cnt_d  = pkt_cnt_q;
      trunc_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (rr_any) begin
               grant_d = rr_next;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (pop) begin
               word_cnt_d = word_cnt_q + WC_W'(1);
            end
            if (close) begin
               state_d    = IDLE;
               word_cnt_d = '0;
               pkt_cnt_d  = pkt_cnt_q + CNT_BITS'(1);
               // Forced close while the source still has more of its packet.
               trunc_d    = force_end && !sel_end;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         grant_q    <= GRANT_W'(N_SRC - 1);
         word_cnt_q <= '0;
         pkt_cnt_q  <= '0;
         trunc_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         word_cnt_q <= word_cnt_d;
         pkt_cnt_q  <= pkt_cnt_d;
         trunc_q    <= trunc_d;
      end
   end

   generate
      for (genvar gi = 0; gi < N_SRC; gi++) begin : g_pop
         assign src_pop[gi] = pop && (grant_q == GRANT_W'(gi));
      end
   endgenerate

   assign fr_shift    = pop;
   assign fr_data     = sel_data;
   assign fr_end      = sel_end || force_end;
   assign grant_id    = grant_q;
   assign busy        = (state_q == BUSY);
   assign trunc_pulse = trunc_q;
   assign pkt_count   = pkt_cnt_q;

endmodule

// File: tb/tb_packet_source_arbiter.sv
// Directed testbench for packet_source_arbiter (N_SRC=4, DATA_BITS=4,
// MAX_WORDS=16). Sources are modelled as simple FIFOs filled by push();
// every framer shift is logged and checked against hand-derived values.
module tb_packet_source_arbiter;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [3:0]  src_nempty;
   logic [3:0]  src_pop;
   logic [15:0] src_data;
   logic [3:0]  src_end;
   logic        fr_full = 1'b0;
   logic        fr_shift;
   logic [3:0]  fr_data;
   logic        fr_end;
   logic [1:0]  grant_id;
   logic        busy;
   logic        trunc_pulse;
   logic [15:0] pkt_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   packet_source_arbiter #(
      .N_SRC     (4),
      .DATA_BITS (4),
      .MAX_WORDS (16),
      .CNT_BITS  (16)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .src_nempty  (src_nempty),
      .src_pop     (src_pop),
      .src_data    (src_data),
      .src_end     (src_end),
      .fr_full     (fr_full),
      .fr_shift    (fr_shift),
      .fr_data     (fr_data),
      .fr_end      (fr_end),
      .grant_id    (grant_id),
      .busy        (busy),
      .trunc_pulse (trunc_pulse),
      .pkt_count   (pkt_count)
   );

   // ---------------- source FIFO model ----------------
   logic [3:0] qd [4][256];
   logic       qe [4][256];
   int         tail [4];
   int         head [4];
   logic       flush = 1'b0;

   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (flush) head[i] <= tail[i];
         else if (src_pop[i]) head[i] <= head[i] + 1;
      end
   end

   always_comb begin
      src_nempty = '0;
      src_data   = '0;
      src_end    = '0;
      for (int i = 0; i < 4; i++) begin
         src_nempty[i]      = (head[i] != tail[i]);
         src_data[i*4 +: 4] = qd[i][head[i][7:0]];
         src_end[i]         = qe[i][head[i][7:0]];
      end
   end

   task automatic push(input int s, input logic [3:0] d, input logic e);
      qd[s][tail[s]] = d;
      qe[s][tail[s]] = e;
      tail[s] = tail[s] + 1;
   endtask

   // ---------------- shift monitor ----------------
   int         cyc = 0;
   int         n = 0;
   int         trunc_cnt = 0;
   logic [1:0] lsrc   [512];
   logic [3:0] ldata  [512];
   logic       lend   [512];
   logic       lfull  [512];
   logic       lonehot[512];
   int         lcyc   [512];

   function automatic logic [1:0] enc(input logic [3:0] v);
      logic [1:0] r;
      r = 2'd0;
      for (int i = 0; i < 4; i++) if (v[i]) r = 2'(i);
      return r;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (fr_shift) begin
         lsrc[n]    <= enc(src_pop);
         ldata[n]   <= fr_data;
         lend[n]    <= fr_end;
         lfull[n]   <= fr_full;
         lonehot[n] <= $onehot(src_pop) && src_pop[grant_id];
         lcyc[n]    <= cyc;
         n          <= n + 1;
      end
      if (trunc_pulse) trunc_cnt <= trunc_cnt + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_log(input int target, input int budget, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         #1;
         if (n >= target) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset_n = 1'b0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      for (int i = 0; i < 4; i++) push(i, 4'd0, 1'b1);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         #1;
         checks++;
         if (src_pop !== 4'b0 || fr_shift !== 1'b0) begin
            errors++;
            $display("FAIL reset_pop: src_pop=%b fr_shift=%b required 0000/0", src_pop, fr_shift);
         end
      end
      tick();
      checks++;
      if (grant_id !== 2'd3) begin
         errors++;
         $display("FAIL reset_grant: got %0d required 3", grant_id);
      end
      checks++;
      if (pkt_count !== 16'd0 || busy !== 1'b0 || trunc_pulse !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: pkt_count=%0d busy=%b trunc=%b required 0/0/0",
                  pkt_count, busy, trunc_pulse);
      end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      reset_n = 1'b1;
      $display("test_reset done");
   endtask

   task automatic test_round_robin();
      int s;
      bit ok;
      logic [1:0] es;
      logic [3:0] ed;
      s = n;
      for (int i = 0; i < 4; i++) begin
         push(i, 4'(i*4), 1'b0);
         push(i, 4'(i*4 + 1), 1'b1);
      end
      push(0, 4'd2, 1'b0);
      push(0, 4'd3, 1'b1);
      wait_log(s + 10, 100, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL rr_timeout: got %0d shifts required 10", n - s);
      end
      repeat (3) tick();
      for (int k = 0; k < 10; k++) begin
         es = 2'((k / 2) % 4);
         ed = (k < 8) ? 4'(int'(es) * 4 + k % 2) : 4'(2 + k % 2);
         checks++;
         if (lsrc[s+k] !== es || ldata[s+k] !== ed || lend[s+k] !== 1'(k % 2) || lonehot[s+k] !== 1'b1) begin
            errors++;
            $display("FAIL rr_word[%0d]: src=%0d data=%0d end=%b onehot=%b required %0d/%0d/%0d/1",
                     k, lsrc[s+k], ldata[s+k], lend[s+k], lonehot[s+k], es, ed, k % 2);
         end
         if (k > 0) begin
            checks++;
            if (lcyc[s+k] - lcyc[s+k-1] != ((k % 2) ? 1 : 2)) begin
               errors++;
               $display("FAIL rr_gap[%0d]: got %0d cycles required %0d",
                        k, lcyc[s+k] - lcyc[s+k-1], (k % 2) ? 1 : 2);
            end
         end
      end
      checks++;
      if (pkt_count !== 16'd5) begin
         errors++;
         $display("FAIL rr_pkt_count: got %0d required 5", pkt_count);
      end
      $display("test_round_robin done: %0d shifts", n - s);
   endtask

   task automatic test_backpressure();
      int s;
      s = n;
      for (int j = 1; j <= 5; j++) push(2, 4'(j), 1'(j == 5));
      for (int c = 0; c < 30; c++) begin
         fr_full = (c % 2 == 0);
         tick();
      end
      fr_full = 1'b0;
      repeat (3) tick();
      checks++;
      if (n - s != 5) begin
         errors++;
         $display("FAIL bp_count: got %0d shifts required 5", n - s);
      end
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (lsrc[s+k] !== 2'd2 || ldata[s+k] !== 4'(k + 1) || lend[s+k] !== 1'(k == 4) || lfull[s+k] !== 1'b0) begin
            errors++;
            $display("FAIL bp_word[%0d]: src=%0d data=%0d end=%b full=%b required 2/%0d/%0d/0",
                     k, lsrc[s+k], ldata[s+k], lend[s+k], lfull[s+k], k + 1, k == 4);
         end
      end
      checks++;
      if (pkt_count !== 16'd6) begin
         errors++;
         $display("FAIL bp_pkt_count: got %0d required 6", pkt_count);
      end
      $display("test_backpressure done: %0d shifts", n - s);
   endtask

   task automatic test_truncation();
      int s, t0;
      bit ok;
      s = n;
      t0 = trunc_cnt;
      for (int j = 0; j < 20; j++) push(1, 4'(j % 16), 1'(j == 19));
      wait_log(s + 20, 200, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL trunc_timeout: got %0d shifts required 20", n - s);
      end
      repeat (3) tick();
      for (int k = 0; k < 20; k++) begin
         checks++;
         if (lsrc[s+k] !== 2'd1 || ldata[s+k] !== 4'(k % 16) || lend[s+k] !== 1'(k == 15 || k == 19)) begin
            errors++;
            $display("FAIL trunc_word[%0d]: src=%0d data=%0d end=%b required 1/%0d/%0d",
                     k, lsrc[s+k], ldata[s+k], lend[s+k], k % 16, (k == 15 || k == 19));
         end
      end
      checks++;
      if (trunc_cnt - t0 != 1) begin
         errors++;
         $display("FAIL trunc_pulses: got %0d required 1", trunc_cnt - t0);
      end
      checks++;
      if (pkt_count !== 16'd8) begin
         errors++;
         $display("FAIL trunc_pkt_count: got %0d required 8", pkt_count);
      end
      $display("test_truncation done: %0d shifts", n - s);
   endtask

   task automatic test_starvation();
      int s;
      bit ok;
      logic [1:0] es [5];
      logic [3:0] ed [5];
      logic       ee [5];
      es = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1};
      ed = '{4'd10, 4'd11, 4'd12, 4'd1, 4'd2};
      ee = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      s = n;
      push(0, 4'd10, 1'b0);
      push(0, 4'd11, 1'b0);
      push(1, 4'd1, 1'b0);
      push(1, 4'd2, 1'b1);
      repeat (12) tick();
      checks++;
      if (n - s != 2 || busy !== 1'b1 || grant_id !== 2'd0 || src_pop !== 4'b0) begin
         errors++;
         $display("FAIL starve_hold: shifts=%0d busy=%b grant=%0d pop=%b required 2/1/0/0000",
                  n - s, busy, grant_id, src_pop);
      end
      push(0, 4'd12, 1'b1);
      wait_log(s + 5, 50, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL starve_timeout: got %0d shifts required 5", n - s);
      end
      repeat (3) tick();
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (lsrc[s+k] !== es[k] || ldata[s+k] !== ed[k] || lend[s+k] !== ee[k]) begin
            errors++;
            $display("FAIL starve_word[%0d]: src=%0d data=%0d end=%b required %0d/%0d/%0d",
                     k, lsrc[s+k], ldata[s+k], lend[s+k], es[k], ed[k], ee[k]);
         end
      end
      checks++;
      if (pkt_count !== 16'd10) begin
         errors++;
         $display("FAIL starve_pkt_count: got %0d required 10", pkt_count);
      end
      $display("test_starvation done: %0d shifts", n - s);
   endtask

   task automatic test_reset_mid_packet();
      int s, t0;
      bit ok;
      s = n;
      for (int j = 0; j < 6; j++) push(2, 4'(j), 1'(j == 5));
      wait_log(s + 3, 50, ok);
      tick();
      reset_n = 1'b0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      tick();
      checks++;
      if (!ok || n - s != 3) begin
         errors++;
         $display("FAIL rmid_partial: got %0d shifts required 3", n - s);
      end
      checks++;
      if (busy !== 1'b0 || grant_id !== 2'd3 || pkt_count !== 16'd0) begin
         errors++;
         $display("FAIL rmid_state: busy=%b grant=%0d pkt_count=%0d required 0/3/0",
                  busy, grant_id, pkt_count);
      end
      reset_n = 1'b1;
      s = n;
      t0 = trunc_cnt;
      push(2, 4'd9, 1'b1);
      for (int j = 0; j < 16; j++) push(0, 4'(j), 1'(j == 15));
      wait_log(s + 17, 100, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL rmid_timeout: got %0d shifts required 17", n - s);
      end
      repeat (3) tick();
      for (int k = 0; k < 17; k++) begin
         checks++;
         if (k < 16) begin
            if (lsrc[s+k] !== 2'd0 || ldata[s+k] !== 4'(k) || lend[s+k] !== 1'(k == 15)) begin
               errors++;
               $display("FAIL rmid_word[%0d]: src=%0d data=%0d end=%b required 0/%0d/%0d",
                        k, lsrc[s+k], ldata[s+k], lend[s+k], k, k == 15);
            end
         end else begin
            if (lsrc[s+k] !== 2'd2 || ldata[s+k] !== 4'd9 || lend[s+k] !== 1'b1) begin
               errors++;
               $display("FAIL rmid_word[%0d]: src=%0d data=%0d end=%b required 2/9/1",
                        k, lsrc[s+k], ldata[s+k], lend[s+k]);
            end
         end
      end
      checks++;
      if (trunc_cnt != t0 || pkt_count !== 16'd2) begin
         errors++;
         $display("FAIL rmid_after: trunc=%0d pkt_count=%0d required 0/2", trunc_cnt - t0, pkt_count);
      end
      $display("test_reset_mid_packet done: %0d shifts", n - s);
   endtask

   initial begin
      for (int i = 0; i < 4; i++) tail[i] = 0;
      test_reset();
      test_round_robin();
      test_backpressure();
      test_truncation();
      test_starvation();
      test_reset_mid_packet();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule
